// File: rtl/ym_mem_pkg.sv
// ym_mem_pkg: shared types and defaults for the YM sound-memory arbiter.
package ym_mem_pkg;

    localparam int YM_AW = 16;
    localparam int YM_DW = 8;

    typedef enum logic [1:0] {IDLE, CPU_RD, CPU_WR, LD_WR} arb_state_t;

    typedef struct packed {
        logic [YM_AW-1:0] addr;
        logic [YM_DW-1:0] data;
    } ld_entry_t;

    function automatic logic in_window(input logic [31:0] a, input logic [31:0] lo, input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/ym_ld_fifo.sv
// ym_ld_fifo: synchronous FIFO buffering translated ROM-loader writes.
import ym_mem_pkg::*;

module ym_ld_fifo #(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  ld_entry_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output ld_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    ld_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;
    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_count_nx;

    assign w_push     = push && !r_full;
    assign w_pop      = pop && !r_empty;
    assign w_count_nx = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

    // Flags are registered from the next count so they settle one cycle after push/pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= push_data;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop)
                r_rp <= r_rp + AW'(1);
            r_count <= w_count_nx;
            r_full  <= w_count_nx == (AW+1)'(DEPTH);
            r_empty <= w_count_nx == '0;
        end
    end

    assign full  = r_full;
    assign empty = r_empty;
    assign head  = r_mem[r_rp];

endmodule

// File: rtl/ym_mem_arbiter.sv
// ym_mem_arbiter: shares the YM PSRAM controller between the sound CPU and the ROM loader.
// Define YM_ARB_TIMEOUT_EN to abort accesses whose ack never arrives.
import ym_mem_pkg::*;

module ym_mem_arbiter #(
    parameter int          ADDRESS_BITS   = YM_AW,
    parameter int          DATA_BITS      = YM_DW,
    parameter logic [31:0] ROM_ADDR_FROM  = 32'h00020000,
    parameter logic [31:0] ROM_ADDR_TO    = 32'h0002bfff,
    parameter int          LD_FIFO_DEPTH  = 4,
    parameter int          TIMEOUT_CYCLES = 63
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cpu_rd,
    input  logic                    cpu_wr,
    input  logic [ADDRESS_BITS-1:0] cpu_addr,
    input  logic [DATA_BITS-1:0]    cpu_wr_data,
    output logic [DATA_BITS-1:0]    cpu_rd_data,
    output logic                    cpu_wait,
    input  logic                    ld_wr,
    input  logic [31:0]             ld_addr,
    input  logic [DATA_BITS-1:0]    ld_wr_data,
    output logic                    ld_full,
    output logic                    mem_rd_en,
    output logic                    mem_wr_en,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [DATA_BITS-1:0]    mem_wr_data,
    input  logic                    mem_rd_ack,
    input  logic                    mem_wr_ack,
    input  logic [DATA_BITS-1:0]    mem_rd_data,
    output logic [1:0]              err
);

    arb_state_t              r_state;
    logic                    r_cpu_pend;
    logic                    r_cpu_wr;
    logic [ADDRESS_BITS-1:0] r_cpu_addr;
    logic [DATA_BITS-1:0]    r_cpu_data;
    logic [DATA_BITS-1:0]    r_rd_data;
    logic                    r_rd_en;
    logic                    r_wr_en;
    logic [ADDRESS_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0]    r_wdata;
    logic [1:0]              r_err;

    logic                    w_cpu_req;
    logic                    w_cpu_acc;
    logic                    w_in_win;
    logic                    w_ld_push;
    logic                    w_ld_drop;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_tmo;
    logic                    w_go_wr;
    logic [ADDRESS_BITS-1:0] w_go_addr;
    logic [DATA_BITS-1:0]    w_go_data;
    ld_entry_t               w_push_entry;
    ld_entry_t               w_head;

    assign w_cpu_req = cpu_rd || cpu_wr;
    assign w_cpu_acc = w_cpu_req && !r_cpu_pend;
    assign w_in_win  = in_window(ld_addr, ROM_ADDR_FROM, ROM_ADDR_TO);
    assign w_ld_push = ld_wr && w_in_win && !w_full;
    assign w_ld_drop = ld_wr && w_in_win && w_full;
    assign w_pop     = (r_state == LD_WR) && (mem_wr_ack || w_tmo);

    // An idle arbiter dispatches a fresh pulse directly so the command lands on the next cycle.
    assign w_go_wr   = r_cpu_pend ? r_cpu_wr   : cpu_wr;
    assign w_go_addr = r_cpu_pend ? r_cpu_addr : cpu_addr;
    assign w_go_data = r_cpu_pend ? r_cpu_data : cpu_wr_data;

    assign w_push_entry.addr = YM_AW'(ld_addr - ROM_ADDR_FROM);
    assign w_push_entry.data = YM_DW'(ld_wr_data);

    ym_ld_fifo #(
        .DEPTH(LD_FIFO_DEPTH)
    ) u_ld_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_ld_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

`ifdef YM_ARB_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) < 6) ? 6 : $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    always_ff @(posedge clk)
        r_tmo_cnt <= (!reset_n || r_state == IDLE) ? '0 : r_tmo_cnt + TMO_W'(1);
    assign w_tmo = (r_state != IDLE) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cpu_pend <= 1'b0;
            r_cpu_wr   <= 1'b0;
            r_cpu_addr <= '0;
            r_cpu_data <= '0;
            r_rd_data  <= '0;
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err      <= '0;
        end else begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            if (w_cpu_req && r_cpu_pend)
                r_err[0] <= 1'b1;
            if (w_ld_drop || w_tmo)
                r_err[1] <= 1'b1;
            if (w_cpu_acc) begin
                r_cpu_pend <= 1'b1;
                r_cpu_wr   <= cpu_wr;
                r_cpu_addr <= cpu_addr;
                r_cpu_data <= cpu_wr_data;
            end
            case (r_state)
                IDLE: begin
                    if (r_cpu_pend || w_cpu_acc) begin
                        r_state <= w_go_wr ? CPU_WR : CPU_RD;
                        r_rd_en <= !w_go_wr;
                        r_wr_en <= w_go_wr;
                        r_addr  <= w_go_addr;
                        r_wdata <= w_go_data;
                    end else if (!w_empty) begin
                        r_state <= LD_WR;
                        r_wr_en <= 1'b1;
                        r_addr  <= ADDRESS_BITS'(w_head.addr);
                        r_wdata <= DATA_BITS'(w_head.data);
                    end
                end
                CPU_RD: begin
                    if (mem_rd_ack)
                        r_rd_data <= mem_rd_data;
                    if (mem_rd_ack || w_tmo) begin
                        r_cpu_pend <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                CPU_WR: begin
                    if (mem_wr_ack || w_tmo) begin
                        r_cpu_pend <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                LD_WR: begin
                    if (w_pop)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cpu_rd_data = r_rd_data;
    assign cpu_wait    = r_cpu_pend;
    assign ld_full     = w_full;
    assign mem_rd_en   = r_rd_en;
    assign mem_wr_en   = r_wr_en;
    assign mem_address = r_addr;
    assign mem_wr_data = r_wdata;
    assign err         = r_err;

endmodule

// File: tb/tb_ym_mem_arbiter.sv
// tb_ym_mem_arbiter: directed self-checking bench for ym_mem_arbiter (default build).
module tb_ym_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wr_data = '0;
    logic [7:0]  cpu_rd_data;
    logic        cpu_wait;
    logic        ld_wr = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [7:0]  ld_wr_data = '0;
    logic        ld_full;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [15:0] mem_address;
    logic [7:0]  mem_wr_data;
    logic        mem_rd_ack = 1'b0;
    logic        mem_wr_ack = 1'b0;
    logic [7:0]  mem_rd_data = '0;
    logic [1:0]  err;

    int checks = 0;
    int failures = 0;
    int wc;
    int rc;
    int ec;

    always #5 clk = ~clk;

    ym_mem_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_rd_data (cpu_rd_data),
        .cpu_wait    (cpu_wait),
        .ld_wr       (ld_wr),
        .ld_addr     (ld_addr),
        .ld_wr_data  (ld_wr_data),
        .ld_full     (ld_full),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_address (mem_address),
        .mem_wr_data (mem_wr_data),
        .mem_rd_ack  (mem_rd_ack),
        .mem_wr_ack  (mem_wr_ack),
        .mem_rd_data (mem_rd_data),
        .err         (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rd_data"}, cpu_rd_data, 0);
        chk({tag, "_wait"}, cpu_wait, 0);
        chk({tag, "_ld_full"}, ld_full, 0);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_wr_en"}, mem_wr_en, 0);
        chk({tag, "_addr"}, mem_address, 0);
        chk({tag, "_wdata"}, mem_wr_data, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Optionally waits (bounded) for a write command, checks its address, then acks it.
    task automatic ld_ack(input string tag, input bit wait_en, input logic [15:0] exp_addr);
        if (wait_en) begin
            for (int n = 0; n < 8 && !mem_wr_en; n++)
                tick();
            chk({tag, "_en"}, mem_wr_en, 1);
        end
        chk({tag, "_addr"}, mem_address, exp_addr);
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk_reset("reset");
        reset_n = 1'b1;
        tick();

        // CPU read, ack 6 cycles after the command
        cpu_addr = 16'h1234;
        cpu_rd   = 1'b1;
        tick();
        cpu_rd = 1'b0;
        chk("rd_addr", mem_address, 16'h1234);
        wc = 0;
        rc = 0;
        for (int i = 0; i < 7; i++) begin
            wc += int'(cpu_wait);
            rc += int'(mem_rd_en);
            if (i == 6) begin
                mem_rd_ack  = 1'b1;
                mem_rd_data = 8'hA5;
            end
            tick();
        end
        mem_rd_ack = 1'b0;
        chk("rd_wait_cycles", wc, 7);
        chk("rd_en_pulses", rc, 1);
        chk("rd_wait_low", cpu_wait, 0);
        chk("rd_data", cpu_rd_data, 8'hA5);

        // Stray ack in IDLE is ignored
        mem_rd_ack  = 1'b1;
        mem_rd_data = 8'hEE;
        tick();
        mem_rd_ack = 1'b0;
        chk("idle_ack_rd_data", cpu_rd_data, 8'hA5);
        chk("idle_ack_wait", cpu_wait, 0);

        // Loader write in window
        ld_addr    = 32'h00020010;
        ld_wr_data = 8'h3C;
        ld_wr      = 1'b1;
        tick();
        ld_wr = 1'b0;
        chk("ld_not_yet", mem_wr_en, 0);
        tick();
        chk("ld_en", mem_wr_en, 1);
        chk("ld_data", mem_wr_data, 8'h3C);
        ld_ack("ld_first", 1'b0, 16'h0010);

        // Loader write just past the window
        ld_addr = 32'h0002C000;
        ld_wr   = 1'b1;
        tick();
        ld_wr = 1'b0;
        ec = 0;
        for (int i = 0; i < 4; i++) begin
            ec += int'(mem_wr_en);
            tick();
        end
        chk("ld_oob_no_cmd", ec, 0);
        chk("ld_oob_err", err, 0);

        // CPU write and loader push in the same cycle
        cpu_addr    = 16'h0055;
        cpu_wr_data = 8'h77;
        cpu_wr      = 1'b1;
        ld_addr     = 32'h00020020;
        ld_wr_data  = 8'h11;
        ld_wr       = 1'b1;
        tick();
        cpu_wr = 1'b0;
        ld_wr  = 1'b0;
        chk("prio_cpu_en", mem_wr_en, 1);
        chk("prio_cpu_addr", mem_address, 16'h0055);
        chk("prio_cpu_data", mem_wr_data, 8'h77);
        tick();
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        chk("prio_idle_wait", cpu_wait, 0);
        chk("prio_idle_no_cmd", mem_wr_en, 0);
        tick();
        chk("prio_ld_en", mem_wr_en, 1);
        chk("prio_ld_data", mem_wr_data, 8'h11);
        ld_ack("prio_ld", 1'b0, 16'h0020);

        // Five loader writes with acks stalled
        for (int i = 0; i < 5; i++) begin
            ld_addr    = 32'h00020100 + i;
            ld_wr_data = 8'h40 + 8'(i);
            ld_wr      = 1'b1;
            tick();
            if (i == 2)
                chk("fifo_3_not_full", ld_full, 0);
            if (i == 3)
                chk("fifo_4_full", ld_full, 1);
        end
        ld_wr = 1'b0;
        chk("fifo_overflow_err", err, 2'b10);
        ld_ack("drain0", 1'b0, 16'h0100);
        ld_ack("drain1", 1'b1, 16'h0101);
        ld_ack("drain2", 1'b1, 16'h0102);
        ld_ack("drain3", 1'b1, 16'h0103);
        ec = 0;
        for (int i = 0; i < 4; i++) begin
            ec += int'(mem_wr_en);
            tick();
        end
        chk("drain_no_fifth", ec, 0);
        chk("drain_not_full", ld_full, 0);

        // Simultaneous read and write, then overrun while waiting
        cpu_addr    = 16'h0200;
        cpu_wr_data = 8'h99;
        cpu_rd      = 1'b1;
        cpu_wr      = 1'b1;
        tick();
        cpu_wr = 1'b0;
        chk("both_wr_en", mem_wr_en, 1);
        chk("both_rd_en", mem_rd_en, 0);
        chk("both_addr", mem_address, 16'h0200);
        chk("both_data", mem_wr_data, 8'h99);
        tick();
        cpu_rd = 1'b0;
        chk("overrun_err", err, 2'b11);
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        chk("overrun_wait_low", cpu_wait, 0);
        rc = 0;
        for (int i = 0; i < 4; i++) begin
            rc += int'(mem_rd_en);
            tick();
        end
        chk("overrun_no_read", rc, 0);

        // Reset in the middle of a read with a loader write buffered
        cpu_addr   = 16'h0300;
        cpu_rd     = 1'b1;
        ld_addr    = 32'h00020030;
        ld_wr_data = 8'h22;
        ld_wr      = 1'b1;
        tick();
        cpu_rd = 1'b0;
        ld_wr  = 1'b0;
        chk("mid_rd_en", mem_rd_en, 1);
        reset_n = 1'b0;
        tick();
        chk_reset("midreset");
        reset_n     = 1'b1;
        mem_rd_ack  = 1'b1;
        mem_rd_data = 8'h5A;
        tick();
        mem_rd_ack = 1'b0;
        ec = 0;
        for (int i = 0; i < 4; i++) begin
            ec += int'(mem_wr_en) + int'(mem_rd_en);
            tick();
        end
        chk("post_reset_no_cmd", ec, 0);
        chk("post_reset_rd_data", cpu_rd_data, 0);
        chk("post_reset_wait", cpu_wait, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
